// File: rtl/dmem_arbiter.sv
// Purpose : arbitrates the single-port data memory between the CPU MEM stage (C) and a loader/debug master (E).
// Latency : writes ack in the grant cycle; reads ack RD_LAT cycles after the grant cycle.
// Backpres: a requester holds req until its ack; C is stalled (cpu_stall) while pending.
// Ports   : clk/rst (sync, active-high); c_*/e_* request ports (req, we, addr, wdata -> ack, rdata);
//           cpu_stall to the hazard unit; mem_* single-port memory interface; perf_* counters.
// Config  : define DMEM_ARB_PERF_EN to enable the perf_stall / perf_egnt counters (tied to 0 otherwise).
module dmem_arbiter #(
  parameter int Nbits    = 64,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [Nbits-1:0] c_addr,
  input  logic [Nbits-1:0] c_wdata,
  output logic             c_ack,
  output logic [Nbits-1:0] c_rdata,
  output logic             cpu_stall,
  input  logic             e_req,
  input  logic             e_we,
  input  logic [Nbits-1:0] e_addr,
  input  logic [Nbits-1:0] e_wdata,
  output logic             e_ack,
  output logic [Nbits-1:0] e_rdata,
  output logic             mem_re,
  output logic             mem_we,
  output logic [Nbits-1:0] mem_addr,
  output logic [Nbits-1:0] mem_wdata,
  input  logic [Nbits-1:0] mem_rdata,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_egnt
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [2:0] RD_LAT_C   = 3'(RD_LAT);
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [2:0]       rd_cnt_q, rd_cnt_d;
  logic             owner_q, owner_d;      // 0 = C, 1 = E
  logic [Nbits-1:0] addr_q, addr_d;
  logic [Nbits-1:0] wdata_q, wdata_d;
  logic [Nbits-1:0] c_rdata_q, c_rdata_d;
  logic [Nbits-1:0] e_rdata_q, e_rdata_d;
  logic             grant_c, grant_e;
  logic             sel_we;
  logic [Nbits-1:0] sel_addr, sel_wdata;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    e_rdata_d = e_rdata_q;
    grant_c   = 1'b0;
    grant_e   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    c_ack     = 1'b0;
    e_ack     = 1'b0;
    c_rdata   = c_rdata_q;
    e_rdata   = e_rdata_q;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;

    // Nothing is issued or acknowledged in a reset cycle, so an in-flight
    // read dies silently.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          // E wins when C is idle, or once it has lost MAX_WAIT cycles in a row.
          if (e_req && (!c_req || wait_cnt_q >= MAX_WAIT_C)) grant_e = 1'b1;
          else if (c_req)                                     grant_c = 1'b1;

          sel_we    = grant_e ? e_we    : c_we;
          sel_addr  = grant_e ? e_addr  : c_addr;
          sel_wdata = grant_e ? e_wdata : c_wdata;

          if (grant_c || grant_e) begin
            mem_addr = sel_addr;
            addr_d   = sel_addr;
            if (sel_we) begin
              mem_we    = 1'b1;
              mem_wdata = sel_wdata;
              wdata_d   = sel_wdata;
              c_ack     = grant_c;
              e_ack     = grant_e;
            end else begin
              mem_re   = 1'b1;
              owner_d  = grant_e;
              rd_cnt_d = 3'd1;
              state_d  = RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (rd_cnt_q == RD_LAT_C) begin
            if (owner_q) begin
              e_ack     = 1'b1;
              e_rdata   = mem_rdata;
              e_rdata_d = mem_rdata;
            end else begin
              c_ack     = 1'b1;
              c_rdata   = mem_rdata;
              c_rdata_d = mem_rdata;
            end
            rd_cnt_d = 3'd0;
            state_d  = IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 3'd1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Counts cycles E is kept waiting; saturates rather than wrapping.
    wait_cnt_d = wait_cnt_q;
    if (grant_e)                             wait_cnt_d = 8'd0;
    else if (e_req && wait_cnt_q != 8'hFF)   wait_cnt_d = wait_cnt_q + 8'd1;
  end

  assign cpu_stall = c_req & ~c_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      rd_cnt_q   <= 3'd0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_rdata_q  <= '0;
      e_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      c_rdata_q  <= c_rdata_d;
      e_rdata_q  <= e_rdata_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_egnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_egnt_q  <= 32'd0;
    end else begin
      if (cpu_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (grant_e)   perf_egnt_q  <= perf_egnt_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_egnt  = perf_egnt_q;
`else
  assign perf_stall = 32'd0;
  assign perf_egnt  = 32'd0;
`endif

endmodule
